// File: rtl/deconv_pkg.sv
// Shared types and sizing for the deconv2D job sequencer.
// The sequencer's parameters default to these values.
package deconv_pkg;

  localparam int N_DEF          = 2;
  localparam int K_DEF          = 3;
  localparam int PIXEL_BITS_DEF = 8;

  localparam int KW_MAX         = K_DEF;
  localparam int RESULT_WORDS   = N_DEF * N_DEF * K_DEF * K_DEF;
  localparam int CFG_W          = $clog2(K_DEF);
  localparam int PIX_W          = $clog2(N_DEF * N_DEF);
  localparam int ADDR_W         = $clog2(RESULT_WORDS);
  localparam int KCNT_W         = $clog2(K_DEF * K_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_INIT,
    LOAD_K,
    K_GAP,
    SEND_P,
    WAIT_ADD,
    DRAIN
  } seq_state_t;

  // A job needs a non-zero stride and a kernel side in 1..kw_max.
  function automatic logic cfg_ok(input int unsigned stride,
                                  input int unsigned kw,
                                  input int unsigned kw_max);
    return (kw != 0) && (kw <= kw_max) && (stride != 0);
  endfunction

endpackage

// File: rtl/deconv_sequencer.sv
// Sequences one deconv2D job: configuration, kernel load, pixel feed with a
// held pixel index, then drains the result RAM as a valid/ready stream.
module deconv_sequencer
  import deconv_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int K          = KW_MAX,
  parameter int pixel_bits = PIXEL_BITS_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(K)-1:0]              cfg_stride,
  input  logic [$clog2(K)-1:0]              cfg_kernel_width,
  output logic                              busy,
  output logic                              cfg_err,
  output logic                              job_done,
  input  logic                              k_valid,
  output logic                              k_ready,
  input  logic [pixel_bits-1:0]             k_data,
  input  logic                              p_valid,
  output logic                              p_ready,
  input  logic [pixel_bits-1:0]             p_data,
  output logic                              r_valid,
  input  logic                              r_ready,
  output logic [4*pixel_bits-1:0]           r_data,
  output logic                              r_last,
  output logic                              dc_enable,
  output logic                              dc_strobe_kernel,
  output logic                              dc_strobe_pixel,
  output logic [pixel_bits-1:0]             dc_kernel_weight,
  output logic [pixel_bits-1:0]             dc_pixel,
  output logic [$clog2(K)-1:0]              dc_stride,
  output logic [$clog2(K)-1:0]              dc_kernel_width,
  output logic [$clog2(N*N)-1:0]            dc_pixel_number,
  output logic [$clog2(N*N*K*K)-1:0]        dc_result_address,
  input  logic [4*pixel_bits-1:0]           dc_final_output,
  input  logic                              dc_ready,
  input  logic                              dc_done
);

  localparam int CW     = $clog2(K);
  localparam int PW     = $clog2(N * N);
  localparam int AW     = $clog2(N * N * K * K);
  localparam int KCW    = $clog2(K * K + 1);
  localparam int WORDS  = N * N * K * K;
  localparam int PIXELS = N * N;

  seq_state_t       state_reg, state_next;
  logic [CW-1:0]    stride_reg, stride_next;
  logic [CW-1:0]    kw_reg, kw_next;
  logic [KCW-1:0]   k_cnt_reg, k_cnt_next;
  logic [PW-1:0]    pix_cnt_reg, pix_cnt_next;
  logic [AW-1:0]    rd_addr_reg, rd_addr_next;
  logic             add_first_reg, add_first_next;
  logic             cfg_err_reg, cfg_err_next;
  logic             job_done_reg, job_done_next;

  logic [KCW-1:0]   k_total;
  logic [KCW-1:0]   k_cnt_inc;
  logic             start_ok;
  logic             last_word;

  assign k_total   = KCW'(kw_reg) * KCW'(kw_reg);
  assign k_cnt_inc = k_cnt_reg + KCW'(1);
  assign start_ok  = cfg_ok(32'(cfg_stride), 32'(cfg_kernel_width), K);
  assign last_word = (rd_addr_reg == AW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      stride_reg    <= '0;
      kw_reg        <= '0;
      k_cnt_reg     <= '0;
      pix_cnt_reg   <= '0;
      rd_addr_reg   <= '0;
      add_first_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
      job_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stride_reg    <= stride_next;
      kw_reg        <= kw_next;
      k_cnt_reg     <= k_cnt_next;
      pix_cnt_reg   <= pix_cnt_next;
      rd_addr_reg   <= rd_addr_next;
      add_first_reg <= add_first_next;
      cfg_err_reg   <= cfg_err_next;
      job_done_reg  <= job_done_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    stride_next       = stride_reg;
    kw_next           = kw_reg;
    k_cnt_next        = k_cnt_reg;
    pix_cnt_next      = pix_cnt_reg;
    rd_addr_next      = rd_addr_reg;
    add_first_next    = 1'b0;
    cfg_err_next      = 1'b0;
    job_done_next     = 1'b0;
    k_ready           = 1'b0;
    p_ready           = 1'b0;
    r_valid           = 1'b0;
    r_data            = '0;
    r_last            = 1'b0;
    dc_enable         = 1'b0;
    dc_strobe_kernel  = 1'b0;
    dc_strobe_pixel   = 1'b0;
    dc_kernel_weight  = '0;
    dc_pixel          = '0;
    dc_result_address = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            stride_next  = cfg_stride;
            kw_next      = cfg_kernel_width;
            k_cnt_next   = '0;
            pix_cnt_next = '0;
            rd_addr_next = '0;
            state_next   = START;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end

      START: begin
        dc_enable  = 1'b1;
        state_next = WAIT_INIT;
      end

      WAIT_INIT: begin
        if (dc_ready) begin
          state_next = LOAD_K;
        end
      end

      LOAD_K: begin
        k_ready          = 1'b1;
        dc_strobe_kernel = k_valid;
        dc_kernel_weight = k_data;
        if (k_valid) begin
          k_cnt_next = k_cnt_inc;
          if (k_cnt_inc == k_total) begin
            state_next = K_GAP;
          end
        end
      end

      // deconv2D moves from INITIALIZE to ASSIGN_REG here; no strobes allowed.
      K_GAP: begin
        state_next = SEND_P;
      end

      SEND_P: begin
        p_ready         = dc_ready;
        dc_strobe_pixel = p_valid & dc_ready;
        dc_pixel        = p_data;
        if (p_valid && dc_ready) begin
          add_first_next = 1'b1;
          state_next     = WAIT_ADD;
        end
      end

      // deconv2D's ready lingers for one cycle after the strobe, so the first
      // WAIT_ADD cycle must not treat it as the end of the ADD phase.
      WAIT_ADD: begin
        if (dc_done) begin
          rd_addr_next = '0;
          state_next   = DRAIN;
        end else if (!add_first_reg && dc_ready) begin
          if (pix_cnt_reg < PW'(PIXELS - 1)) begin
            pix_cnt_next = pix_cnt_reg + PW'(1);
          end
          state_next = SEND_P;
        end
      end

      DRAIN: begin
        r_valid           = 1'b1;
        r_data            = dc_final_output;
        dc_result_address = rd_addr_reg;
        r_last            = last_word;
        if (r_ready) begin
          if (last_word) begin
            rd_addr_next  = '0;
            k_cnt_next    = '0;
            pix_cnt_next  = '0;
            job_done_next = 1'b1;
            state_next    = IDLE;
          end else begin
            rd_addr_next = rd_addr_reg + AW'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy            = (state_reg != IDLE);
  assign cfg_err         = cfg_err_reg;
  assign job_done        = job_done_reg;
  assign dc_stride       = stride_reg;
  assign dc_kernel_width = kw_reg;
  assign dc_pixel_number = pix_cnt_reg;

endmodule
